mem_block_ctrl: RTL and testbench
=================================

# mem_block_ctrl

Block-transfer memory controller directly downstream of the cache. Accepts whole-block read and write-back requests on the cache's memory port (block address, 4×32-bit block data, busywait, done pulses). Serialises each block into single-word accesses on a 32-bit request/acknowledge SRAM port, and reassembles read blocks for the cache.

## Interface
Parameters:
- `BLOCK_SIZE`, default 2: log2 words per block (4 words).
- `LINE_SIZE`, default 32: word width in bits.
- `ADDR_SIZE`, default 32: byte address width. Block address width `BA = ADDR_SIZE-BLOCK_SIZE-2`, 28 bits by default.
- `TIMEOUT`, default 15: maximum wait for `sram_ack_i` per word, in cycles. Used only with `MEM_CTRL_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: clock. All logic is on the rising edge.
- `reset_i` in 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `m_read_i` in 1: block read request from the cache.
- `m_wr_i` in 1: block write-back request from the cache.
- `m_addr_i` in BA: block address.
- `m_wr_data_i` in 2^BLOCK_SIZE·LINE_SIZE: write block. Word k occupies bits `[k·32+31:k·32]`.
- `m_busywait_o` out 1: the controller is transferring.
- `m_read_data_o` out 2^BLOCK_SIZE·LINE_SIZE: assembled read block, with the same word packing as `m_wr_data_i`.
- `m_write_done_o` out 1: one-cycle pulse, write-back complete.
- `m_read_done_o` out 1: one-cycle pulse, read block valid.
- `m_error_o` out 1: sticky timeout error. Tied to 0 without the macro.
- `sram_req_o` out 1: word access request.
- `sram_we_o` out 1: 1 = write, 0 = read.
- `sram_addr_o` out ADDR_SIZE-2: word address `{block_addr, word_idx}`.
- `sram_wdata_o` out LINE_SIZE: write word.
- `sram_rdata_i` in LINE_SIZE: read word. Valid in the cycle `sram_ack_i` is high.
- `sram_ack_i` in 1: word access complete.

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - `m_wr_i` high → latch `m_addr_i` and `m_wr_data_i`, set `word_idx`=0, go to WRITE.
  - Otherwise `m_read_i` high → latch the address, set `word_idx`=0, go to READ.
  - Write has priority when both are high. The read is taken in a later IDLE cycle if still asserted, which supports the evict-then-fetch sequence.
- WRITE/READ:
  - `sram_req_o`=1, `sram_we_o`=1 in WRITE and 0 in READ.
  - Address and `sram_wdata_o` come from the latched block and `word_idx`; they are held stable until ack.
  - On `sram_ack_i`: in READ, store `sram_rdata_i` into word `word_idx` of `m_read_data_o`; then increment `word_idx`.
  - Ack on word 2^BLOCK_SIZE−1 → go to DONE.
- DONE: pulse `m_write_done_o` or `m_read_done_o` for exactly one cycle, then go to IDLE. Requests are ignored in DONE; the cache must deassert its request on the done pulse.
- `m_read_data_o` keeps its value until the next read overwrites it word by word. Write-backs leave it untouched.
- Latched address and data are immune to input changes mid-transfer.
- `word_idx` is BLOCK_SIZE bits wide and wraps to 0 after the last word.
- `sram_ack_i` is ignored outside WRITE/READ.

## Timing
- Every output is registered except `sram_addr_o`/`sram_wdata_o`, which are muxed from registers.
- Reset (`reset_i`=0 at an edge) sets state IDLE and `word_idx`=0. All outputs go to 0, including `m_read_data_o` and `m_error_o`.
- Reset mid-transfer aborts the transfer: `sram_req_o` drops after that edge and no done pulse is issued.
- Request sampled at edge N → `m_busywait_o`=1 and `sram_req_o`=1 from edge N+1.
- A word acked at the first edge it is requested takes 1 cycle.
- Minimum block latency with zero-wait ack: request edge N, then words at N+1..N+4, DONE at N+5 with done pulse high and busywait 0, IDLE at N+6. A new request can be accepted at edge N+6.
- `m_busywait_o` is 1 exactly in WRITE/READ.

## Configuration
- `MEM_CTRL_TIMEOUT_EN` defined:
  - A per-word counter increments each WRITE/READ cycle without ack and clears on ack.
  - When the counter reaches `TIMEOUT`: abort, set `m_error_o` (sticky until reset), go to DONE, and issue the done pulse for the current request type. Read data words not yet fetched keep their old values.
- `MEM_CTRL_TIMEOUT_EN` undefined: no counter is built, the controller waits indefinitely for ack, and `m_error_o` is constant 0.

## Test plan
- Reset: hold `reset_i`=0 for 2 cycles mid-READ → `sram_req_o`, `m_busywait_o`, done pulses and `m_read_data_o` are 0 at the next edge; the FSM is in IDLE.
- Read, zero-wait ack: SRAM returns word = word address, with `m_addr_i`=0x1 → `sram_addr_o` sequence 4,5,6,7. `m_read_done_o` pulses at N+5. `m_read_data_o`=`{32'd7,32'd6,32'd5,32'd4}`.
- Write with 2-wait ack per word: `m_addr_i`=0x0, block `{32'd3,32'd2,32'd1,32'd0}` → `sram_we_o`=1, addresses 0..3 with matching data. Each word is held for 3 cycles. `m_write_done_o` pulses once at N+13.
- Simultaneous `m_wr_i`/`m_read_i` to 0x2: write words 8..11 first, then `m_write_done_o`. After that, with read still high, read words 8..11 and `m_read_done_o`. The read returns the written data.
- Input change mid-transfer: change `m_addr_i` and `m_wr_data_i` after acceptance → SRAM address and data stay on the latched block.
- With `MEM_CTRL_TIMEOUT_EN`, `TIMEOUT`=15, ack never asserted → after 15 cycles on word 0, the done pulse fires, `m_error_o`=1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_block_ctrl.sv
// Block-transfer memory controller: serialises cache block reads/write-backs into single-word SRAM accesses.
// Optional per-word ack timeout with sticky error is enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_block_ctrl #(
  parameter int BLOCK_SIZE = 2,
  parameter int LINE_SIZE  = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   m_read_i,
  input  logic                                   m_wr_i,
  input  logic [ADDR_SIZE-BLOCK_SIZE-3:0]        m_addr_i,
  input  logic [(2**BLOCK_SIZE)*LINE_SIZE-1:0]   m_wr_data_i,
  output logic                                   m_busywait_o,
  output logic [(2**BLOCK_SIZE)*LINE_SIZE-1:0]   m_read_data_o,
  output logic                                   m_write_done_o,
  output logic                                   m_read_done_o,
  output logic                                   m_error_o,
  output logic                                   sram_req_o,
  output logic                                   sram_we_o,
  output logic [ADDR_SIZE-3:0]                   sram_addr_o,
  output logic [LINE_SIZE-1:0]                   sram_wdata_o,
  input  logic [LINE_SIZE-1:0]                   sram_rdata_i,
  input  logic                                   sram_ack_i
);

  localparam int WORDS = 2**BLOCK_SIZE;
  localparam int BW    = WORDS * LINE_SIZE;
  localparam int BA    = ADDR_SIZE - BLOCK_SIZE - 2;
  localparam logic [BLOCK_SIZE-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e                state_q, state_d;
  logic [BLOCK_SIZE-1:0] idx_q, idx_d;
  logic [BA-1:0]         addr_q, addr_d;
  logic [BW-1:0]         wdata_q, wdata_d;
  logic [BW-1:0]         rdata_q, rdata_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  busy_q, busy_d;
  logic                  we_q, we_d;
  logic                  wdone_q, wdone_d;
  logic                  rdone_q, rdone_d;

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          error_q, error_d;
`endif

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_CTRL_TIMEOUT_EN
    cnt_d   = cnt_q;
    error_d = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_pend_q) begin
          state_d = WRITE;
          idx_d   = '0;
        end else if (rd_pend_q) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      WRITE, READ: begin
        if (sram_ack_i) begin
          if (state_q == READ) rdata_d[int'(idx_q)*LINE_SIZE +: LINE_SIZE] = sram_rdata_i;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
`ifdef MEM_CTRL_TIMEOUT_EN
          cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          error_d = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Requests are captured only on edges that leave the FSM idle; the capture is acted on one edge later.
    wr_pend_d = (state_d == IDLE) && m_wr_i;
    rd_pend_d = (state_d == IDLE) && m_read_i;
    if (state_d == IDLE) begin
      addr_d = m_addr_i;
      if (m_wr_i) wdata_d = m_wr_data_i;
    end

    busy_d  = (state_d == WRITE) || (state_d == READ);
    we_d    = (state_d == WRITE);
    wdone_d = (state_q == WRITE) && (state_d == DONE);
    rdone_d = (state_q == READ)  && (state_d == DONE);
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch; block data registers are cleared too because the read block is a visible output.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      wdone_q   <= 1'b0;
      rdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      wdone_q   <= wdone_d;
      rdone_q   <= rdone_d;
    end
  end

`ifdef MEM_CTRL_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end
  assign m_error_o = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign m_error_o      = 1'b0;
`endif

  assign m_busywait_o   = busy_q;
  assign sram_req_o     = busy_q;
  assign sram_we_o      = we_q;
  assign m_write_done_o = wdone_q;
  assign m_read_done_o  = rdone_q;
  assign m_read_data_o  = rdata_q;
  assign sram_addr_o    = {addr_q, idx_q};
  assign sram_wdata_o   = wdata_q[int'(idx_q)*LINE_SIZE +: LINE_SIZE];

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Directed bench for mem_block_ctrl: behavioural wait-state SRAM model plus hand-computed expectations.
// Define MEM_CTRL_TIMEOUT_EN for both files to exercise the timeout path.
module tb_mem_block_ctrl;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         m_read_i, m_wr_i;
  logic [27:0]  m_addr_i;
  logic [127:0] m_wr_data_i;
  logic         m_busywait_o;
  logic [127:0] m_read_data_o;
  logic         m_write_done_o, m_read_done_o, m_error_o;
  logic         sram_req_o, sram_we_o;
  logic [29:0]  sram_addr_o;
  logic [31:0]  sram_wdata_o;
  logic [31:0]  sram_rdata_i;
  logic         sram_ack_i;

  mem_block_ctrl dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .m_read_i       (m_read_i),
    .m_wr_i         (m_wr_i),
    .m_addr_i       (m_addr_i),
    .m_wr_data_i    (m_wr_data_i),
    .m_busywait_o   (m_busywait_o),
    .m_read_data_o  (m_read_data_o),
    .m_write_done_o (m_write_done_o),
    .m_read_done_o  (m_read_done_o),
    .m_error_o      (m_error_o),
    .sram_req_o     (sram_req_o),
    .sram_we_o      (sram_we_o),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .sram_rdata_i   (sram_rdata_i),
    .sram_ack_i     (sram_ack_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // SRAM model: acks after wait_n idle cycles per word, logs every completed access.
  logic [31:0] mem [64];
  int          wait_n  = 0;
  bit          sram_en = 1'b1;
  int          wcnt    = 0;
  int          hold_viol = 0;
  logic [29:0] held_addr;
  logic [31:0] held_data;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    sram_ack_i   = 1'b0;
    sram_rdata_i = '0;
  end

  always @(negedge clk) begin
    sram_ack_i = 1'b0;
    if (sram_req_o && sram_en) begin
      if (wcnt > 0 && (sram_addr_o != held_addr || sram_wdata_o != held_data)) hold_viol++;
      held_addr = sram_addr_o;
      held_data = sram_wdata_o;
      if (wcnt == wait_n) begin
        sram_ack_i = 1'b1;
        wcnt = 0;
        if (sram_we_o) mem[sram_addr_o[5:0]] = sram_wdata_o;
        else           sram_rdata_i = mem[sram_addr_o[5:0]];
        log_addr.push_back({2'b00, sram_addr_o});
        log_data.push_back(sram_we_o ? sram_wdata_o : mem[sram_addr_o[5:0]]);
        log_we.push_back(sram_we_o);
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    log_we.delete();
  endtask

  // Present a request at a negedge; busywait must stay low for one edge, then rise.
  task automatic issue(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] d);
    m_read_i = rd; m_wr_i = wr; m_addr_i = a; m_wr_data_i = d;
    @(negedge clk);
    check("busy_latency", m_busywait_o, 1'b0);
    @(negedge clk);
    check("busy_on", m_busywait_o, 1'b1);
    check("req_on", sram_req_o, 1'b1);
    check("we", sram_we_o, wr);
  endtask

  // Returns the negedge index (request presented at index 0) where a done pulse is seen, -1 if never.
  task automatic wait_done(output int cyc);
    cyc = 2;
    while (!(m_write_done_o || m_read_done_o) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) cyc = -1;
  endtask

  task automatic finish_xfer(input string tag, input logic exp_w, input logic exp_r, input bit keep_read);
    check({tag, "_wdone"}, m_write_done_o, exp_w);
    check({tag, "_rdone"}, m_read_done_o, exp_r);
    check({tag, "_busy_in_done"}, m_busywait_o, 1'b0);
    m_wr_i = 1'b0;
    if (!keep_read) m_read_i = 1'b0;
    @(negedge clk);
    check({tag, "_pulse_1cyc"}, {m_write_done_o, m_read_done_o, m_busywait_o}, 3'b000);
  endtask

  task automatic check_log(input string tag, input int base, input logic [31:0] d0, input bit we);
    check({tag, "_nwords"}, log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), log_addr[i], 32'(base + i));
      check($sformatf("%s_data%0d", tag, i), log_data[i], d0 + 32'(i));
      check($sformatf("%s_we%0d", tag, i), log_we[i], we);
    end
  endtask

  int cyc;

  initial begin
    reset_i = 1'b0; m_read_i = 1'b0; m_wr_i = 1'b0; m_addr_i = '0; m_wr_data_i = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {m_busywait_o, sram_req_o, sram_we_o, m_write_done_o, m_read_done_o, m_error_o}, 6'b0);
    check("rst_rdata", m_read_data_o, 128'h0);
    check("rst_addr", sram_addr_o, 30'h0);
    reset_i = 1'b1;
    @(negedge clk);

    // Zero-wait read of block 1: words 4..7, done at N+5.
    wait_n = 0; clear_logs();
    issue(1'b1, 1'b0, 28'h1, 128'h0);
    wait_done(cyc);
    check("rd0_latency", cyc, 6);
    finish_xfer("rd0", 1'b0, 1'b1, 1'b0);
    check("rd0_data", m_read_data_o, 128'h00000007_00000006_00000005_00000004);
    check_log("rd0", 4, 32'd4, 1'b0);

    // Write-back of block 0 with two wait states per word: done at N+13.
    wait_n = 2; clear_logs();
    issue(1'b0, 1'b1, 28'h0, 128'h00000003_00000002_00000001_00000000);
    wait_done(cyc);
    check("wr2_latency", cyc, 14);
    finish_xfer("wr2", 1'b1, 1'b0, 1'b0);
    check_log("wr2", 0, 32'd0, 1'b1);
    check("wr2_rdata_kept", m_read_data_o, 128'h00000007_00000006_00000005_00000004);

    // Simultaneous write and read to block 2: write first, then the still-held read.
    wait_n = 1; clear_logs();
    issue(1'b1, 1'b1, 28'h2, 128'h000000A3_000000A2_000000A1_000000A0);
    wait_done(cyc);
    check("sim_wr_seen", cyc > 0, 1'b1);
    finish_xfer("sim_wr", 1'b1, 1'b0, 1'b1);
    check_log("sim_wr", 8, 32'hA0, 1'b1);
    clear_logs();
    wait_done(cyc);
    check("sim_rd_seen", cyc > 0, 1'b1);
    finish_xfer("sim_rd", 1'b0, 1'b1, 1'b0);
    check_log("sim_rd", 8, 32'hA0, 1'b0);
    check("sim_rd_data", m_read_data_o, 128'h000000A3_000000A2_000000A1_000000A0);

    // Inputs change right after acceptance; the transfer must stay on the latched block.
    wait_n = 1; clear_logs();
    issue(1'b0, 1'b1, 28'h3, 128'h000000B3_000000B2_000000B1_000000B0);
    m_addr_i = 28'h5; m_wr_data_i = {4{32'hFFFF_FFFF}};
    wait_done(cyc);
    check("chg_seen", cyc > 0, 1'b1);
    finish_xfer("chg", 1'b1, 1'b0, 1'b0);
    check_log("chg", 12, 32'hB0, 1'b1);

    // SRAM never acks while disabled.
    sram_en = 1'b0; wait_n = 0; clear_logs();
    issue(1'b1, 1'b0, 28'h4, 128'h0);
`ifdef MEM_CTRL_TIMEOUT_EN
    wait_done(cyc);
    check("tmo_latency", cyc, 17);
    check("tmo_error_at_done", m_error_o, 1'b1);
    finish_xfer("tmo", 1'b0, 1'b1, 1'b0);
    check("tmo_rdata_kept", m_read_data_o, 128'h000000A3_000000A2_000000A1_000000A0);
    repeat (5) @(negedge clk);
    check("tmo_error_sticky", m_error_o, 1'b1);
    sram_en = 1'b1;
`else
    repeat (20) @(negedge clk);
    check("noack_busy", m_busywait_o, 1'b1);
    check("noack_addr", sram_addr_o, 30'h10);
    check("noack_error", m_error_o, 1'b0);
    sram_en = 1'b1;
    wait_done(cyc);
    check("noack_seen", cyc > 0, 1'b1);
    finish_xfer("noack", 1'b0, 1'b1, 1'b0);
    check("noack_data", m_read_data_o, 128'h00000013_00000012_00000011_00000010);
`endif

    // Reset held two cycles in the middle of a read.
    wait_n = 3;
    issue(1'b1, 1'b0, 28'h1, 128'h0);
    @(negedge clk);
    reset_i = 1'b0; m_read_i = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", {m_busywait_o, sram_req_o, m_write_done_o, m_read_done_o, m_error_o}, 5'b0);
    check("mid_rst_rdata", m_read_data_o, 128'h0);
    @(negedge clk);
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {m_busywait_o, m_write_done_o, m_read_done_o}, 3'b000);

    // FSM resumes cleanly from IDLE after the aborted transfer.
    wait_n = 0; clear_logs();
    issue(1'b1, 1'b0, 28'h1, 128'h0);
    wait_done(cyc);
    check("post_rst_latency", cyc, 6);
    finish_xfer("post_rst", 1'b0, 1'b1, 1'b0);
    check("post_rst_data", m_read_data_o, 128'h00000007_00000006_00000005_00000004);

    check("addr_data_hold", hold_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
